// File: rtl/regfile_2r1w.sv
// 2-read/1-write register file with entry 0 hardwired to zero; reads are combinational, writes land on the next edge.
// No internal bypass, no backpressure; a write takes priority over a same-edge clear.
module regfile_2r1w #(
  parameter type t_entry     = logic [31:0],
  parameter int  p_num_regs  = 32,
  localparam int p_addr_bits = $clog2(p_num_regs)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [p_addr_bits-1:0] raddr [1:0],
  output t_entry                 rdata [1:0],
  input  logic [p_addr_bits-1:0] waddr,
  input  t_entry                 wdata,
  input  logic                   wen
);

  // Entry 0 has no storage; its reads are forced to zero below.
  t_entry r_mem [1:p_num_regs-1];

  logic w_wr_hit;
  assign w_wr_hit = wen && (waddr != '0) && (int'(waddr) < p_num_regs);

  // An in-flight writeback wins over a flush-style reset on the same edge.
  always_ff @(posedge clk) begin
    if (wen) begin
      if (w_wr_hit) begin
        r_mem[waddr] <= wdata;
      end
    end else if (rst) begin
      for (int k = 1; k < p_num_regs; k++) begin
        r_mem[k] <= '0;
      end
    end
  end

  for (genvar gi = 0; gi < 2; gi++) begin : g_rd
    logic w_rd_hit;
    assign w_rd_hit  = (raddr[gi] != '0) && (int'(raddr[gi]) < p_num_regs);
    assign rdata[gi] = w_rd_hit ? r_mem[raddr[gi]] : '0;
  end

endmodule

// File: tb/tb_regfile_2r1w.sv
// Scoreboard bench for regfile_2r1w across four width/depth configurations.
// Stimulus pushes expected read data; a negedge monitor pops and compares.
module tb_regfile_2r1w;

  logic clk;
  logic rst;
  logic [5:0]  ra0, ra1, wa;
  logic [31:0] wd;
  logic        we;
  int          sel;
  logic        chk_vld;
  int          chk_id;

  // Instance A: 32/32, B: 16/32, C: 32/8, D: 8/64
  logic [4:0]  a_ra [1:0];
  logic [31:0] a_rd [1:0];
  logic        a_we;
  logic [4:0]  b_ra [1:0];
  logic [15:0] b_rd [1:0];
  logic        b_we;
  logic [2:0]  c_ra [1:0];
  logic [31:0] c_rd [1:0];
  logic        c_we;
  logic [5:0]  d_ra [1:0];
  logic [7:0]  d_rd [1:0];
  logic        d_we;

  always_comb begin
    a_ra[0] = ra0[4:0]; a_ra[1] = ra1[4:0];
    b_ra[0] = ra0[4:0]; b_ra[1] = ra1[4:0];
    c_ra[0] = ra0[2:0]; c_ra[1] = ra1[2:0];
    d_ra[0] = ra0;      d_ra[1] = ra1;
    a_we = we && (sel == 0);
    b_we = we && (sel == 1);
    c_we = we && (sel == 2);
    d_we = we && (sel == 3);
  end

  regfile_2r1w #(.t_entry(logic [31:0]), .p_num_regs(32)) u_a (
    .clk(clk), .rst(rst), .raddr(a_ra), .rdata(a_rd),
    .waddr(wa[4:0]), .wdata(wd), .wen(a_we));
  regfile_2r1w #(.t_entry(logic [15:0]), .p_num_regs(32)) u_b (
    .clk(clk), .rst(rst), .raddr(b_ra), .rdata(b_rd),
    .waddr(wa[4:0]), .wdata(wd[15:0]), .wen(b_we));
  regfile_2r1w #(.t_entry(logic [31:0]), .p_num_regs(8)) u_c (
    .clk(clk), .rst(rst), .raddr(c_ra), .rdata(c_rd),
    .waddr(wa[2:0]), .wdata(wd), .wen(c_we));
  regfile_2r1w #(.t_entry(logic [7:0]), .p_num_regs(64)) u_d (
    .clk(clk), .rst(rst), .raddr(d_ra), .rdata(d_rd),
    .waddr(wa), .wdata(wd[7:0]), .wen(d_we));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] e0;
    logic [31:0] e1;
    string       name;
  } exp_t;

  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  logic [31:0] model [64];

  function automatic int nregs(int id);
    case (id)
      0: return 32;
      1: return 32;
      2: return 8;
      default: return 64;
    endcase
  endfunction

  function automatic logic [31:0] wmask(int id);
    case (id)
      1: return 32'h0000_ffff;
      3: return 32'h0000_00ff;
      default: return 32'hffff_ffff;
    endcase
  endfunction

  function automatic logic [31:0] mread(int id, int a);
    if (a == 0 || a >= nregs(id)) return 32'h0;
    return model[a];
  endfunction

  // One cycle: drive after the edge, record the expected combinational reads.
  task automatic cyc(input int id, input int r0, input int r1, input int waddr,
                     input logic [31:0] wdat, input logic wen_i, input logic rst_i,
                     input logic [31:0] e0, input logic [31:0] e1, input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    sel = id;
    ra0 = 6'(r0); ra1 = 6'(r1); wa = 6'(waddr);
    wd = wdat; we = wen_i; rst = rst_i;
    e.id = id; e.e0 = e0; e.e1 = e1; e.name = nm;
    sb.push_back(e);
    chk_id  = id;
    chk_vld = 1'b1;
  endtask

  // Model-tracked cycle: expectation from the reference array, then update it.
  task automatic mcyc(input int id, input int r0, input int r1, input int waddr,
                      input logic [31:0] wdat, input logic wen_i, input logic rst_i,
                      input string nm);
    logic [31:0] v;
    v = wdat & wmask(id);
    cyc(id, r0, r1, waddr, v, wen_i, rst_i, mread(id, r0), mread(id, r1), nm);
    if (wen_i) begin
      if (waddr != 0 && waddr < nregs(id)) model[waddr] = v;
    end else if (rst_i) begin
      for (int k = 0; k < 64; k++) model[k] = 32'h0;
    end
  endtask

  always @(negedge clk) begin
    if (chk_vld) begin
      logic [31:0] g0, g1;
      exp_t        e;
      case (chk_id)
        0: begin g0 = a_rd[0];          g1 = a_rd[1];          end
        1: begin g0 = {16'h0, b_rd[0]}; g1 = {16'h0, b_rd[1]}; end
        2: begin g0 = c_rd[0];          g1 = c_rd[1];          end
        default: begin g0 = {24'h0, d_rd[0]}; g1 = {24'h0, d_rd[1]}; end
      endcase
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_underflow: read presented with no expectation queued");
      end else begin
        e = sb.pop_front();
        if (g0 !== e.e0) begin
          errors++;
          $display("FAIL %s port0 cfg%0d: got %h expected %h", e.name, e.id, g0, e.e0);
        end
        checks++;
        if (g1 !== e.e1) begin
          errors++;
          $display("FAIL %s port1 cfg%0d: got %h expected %h", e.name, e.id, g1, e.e1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] v;
    int r0, r1, wad;
    logic w;
    rst = 1'b1; we = 1'b0; sel = 0; chk_vld = 1'b0; chk_id = 0;
    ra0 = '0; ra1 = '0; wa = '0; wd = '0;

    // Directed vectors on the 32/32 instance
    cyc(0, 0, 0, 0, 32'h0,      0, 1, 32'h0,    32'h0,    "rst_zero");
    cyc(0, 0, 0, 0, 32'h0,      0, 1, 32'h0,    32'h0,    "rst_zero2");
    cyc(0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    32'h0,    "out_of_reset");
    cyc(0, 1, 1, 1, 32'habcd,   1, 0, 32'h0,    32'h0,    "wr_same_cycle");
    cyc(0, 1, 1, 0, 32'h0,      0, 0, 32'habcd, 32'habcd, "wr_visible");
    cyc(0, 5, 1, 5, 32'hf00d,   1, 0, 32'h0,    32'habcd, "wr5");
    cyc(0, 5, 1, 0, 32'h0,      0, 1, 32'hf00d, 32'habcd, "rst_cycle_old");
    cyc(0, 5, 1, 0, 32'h0,      0, 0, 32'h0,    32'h0,    "rst_cleared");
    cyc(0, 0, 0, 0, 32'hbaad,   1, 0, 32'h0,    32'h0,    "zero_wr");
    cyc(0, 0, 0, 0, 32'h4321,   1, 1, 32'h0,    32'h0,    "zero_wr_rst");
    cyc(0, 0, 0, 0, 32'h0,      0, 0, 32'h0,    32'h0,    "zero_after");
    cyc(0, 6, 7, 6, 32'h1234,   1, 0, 32'h0,    32'h0,    "wr6");
    cyc(0, 6, 7, 7, 32'h5678,   1, 1, 32'h1234, 32'h0,    "wr7_in_rst");
    cyc(0, 6, 7, 0, 32'h0,      0, 0, 32'h1234, 32'h5678, "rd_6_7");
    cyc(0, 7, 6, 31, 32'hdeadbeef, 1, 0, 32'h5678, 32'h1234, "rd_7_6");
    cyc(0, 31, 5, 0, 32'h0,     0, 0, 32'hdeadbeef, 32'h0, "full_width");

    // Fill every entry of each configuration
    for (int id = 0; id < 4; id++) begin
      mcyc(id, 0, 0, 0, 32'h0, 0, 1, "fill_rst");
      for (int i = 1; i < nregs(id); i++) begin
        v = $urandom;
        mcyc(id, i - 1, i - 1, i, v, 1, 0, "fill");
      end
      mcyc(id, nregs(id) - 1, 1, 0, 32'h0, 0, 0, "fill_last");
    end

    // Random traffic with forced read-of-written-address and writes to 0
    mcyc(0, 0, 0, 0, 32'h0, 0, 1, "rand_rst");
    for (int c = 0; c < 20; c++) begin
      wad = $urandom_range(0, 31);
      r1  = $urandom_range(0, 31);
      w   = 1'($urandom_range(0, 1));
      if (c == 3 || c == 11) begin wad = 0; w = 1'b1; end
      r0  = (c % 2 == 0) ? wad : $urandom_range(0, 31);
      mcyc(0, r0, r1, wad, $urandom, w, 0, "random");
    end
    mcyc(0, 0, 0, 0, 32'h0, 0, 0, "rand_tail");

    @(posedge clk);
    #1;
    chk_vld = 1'b0;
    we = 1'b0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d expectations left, required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_2r1w.md
Name: regfile_2r1w

Overview:
- Parameterized 2-read / 1-write architectural register file for the decode/issue stage.
- Entry 0 is hardwired to zero.
- Reads are combinational; the write is synchronous on the rising edge of clk.
- A synchronous reset clears all entries to zero.

Parameters:
- t_entry, default logic [31:0]: type of each register entry. Defines data width W; benches use 8, 16 and 32 bits.
- p_num_regs, default 32: number of entries, including entry 0. Benches use 8, 32 and 64.
- Derived localparam p_addr_bits = $clog2(p_num_regs): address width A.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- raddr  input  unpacked array [1:0] of A bits  read addresses, ports 0 and 1.
- rdata  output  unpacked array [1:0] of t_entry  read data, ports 0 and 1.
- waddr  input  A  write address.
- wdata  input  t_entry  write data.
- wen  input  1  write enable.

Behaviour:
- Storage: p_num_regs entries of type t_entry. Entry 0 is not stored and always reads as '0.
- Read ports:
  - Purely combinational: rdata[i] = entry[raddr[i]] within the same cycle.
  - The two ports are fully independent; both may address the same entry.
  - raddr[i] == 0 gives rdata[i] = '0.
  - An address >= p_num_regs (only possible when p_num_regs is not a power of 2) gives rdata[i] = '0.
- Write port:
  - On a rising edge with wen=1 and waddr != 0, entry[waddr] <= wdata.
  - A write to address 0 is discarded.
  - A write to an address >= p_num_regs is discarded.
- Write-to-read timing:
  - No internal bypass. A read of the address being written in the same cycle returns the OLD value.
  - The new value is visible from the cycle after the write edge (1-cycle write-to-read latency).
- Reset:
  - On a rising edge with rst=1 and wen=0, all entries are cleared to '0.
  - Reset is synchronous, so during the reset cycle itself reads still return the pre-reset contents.
- Priority of wen over rst:
  - On a rising edge with rst=1 and wen=1, the write is performed and NO clear occurs that cycle; all other entries keep their values.
  - This allows an in-flight writeback to complete during a flush-style reset.
- Reset values: after any clearing reset, every entry reads '0. No outputs are registered, so no other reset values apply.
- Power-up contents are undefined until the first clearing reset. The environment always resets before use.
- Width rules:
  - wdata is stored unmodified at the full t_entry width.
  - There is no sign or zero extension.

Test Plan:
- Basic:
  - Out of reset, read (0,0) -> both ports 0.
  - Write addr1=0xabcd with wen=1; that cycle reads are unaffected.
  - Next cycle read (1,1) -> 0xabcd on both ports.
- Reset clears:
  - Write addr5=0xf00d.
  - Next cycle rst=1, wen=0, read addr5 -> 0xf00d (still visible during the reset cycle).
  - Following cycle read addr5 -> 0x0000.
- Zero register:
  - Write addr0=0xbaad, then rst=1 with a write of addr0=0x4321.
  - Read addr0 on both ports every cycle -> always 0x0000.
- Write during reset:
  - Write addr6=0x1234.
  - Next cycle rst=1 with wen=1 writing addr7=0x5678.
  - Then read (6,7) -> (0x1234, 0x5678), and read (7,6) -> (0x5678, 0x1234).
- Fill all entries:
  - For i = 1..p_num_regs-1, write a random value to addr i while reading addr i-1 on both ports.
  - Each read returns the value written the previous cycle (addr0 reads 0).
  - Repeat for W/N = 32/32, 16/32, 32/8 and 8/64.
- Random:
  - 20 cycles of random raddr0, raddr1, waddr, wdata and wen, compared against a reference array initialized to zero and updated after each cycle.
  - Same-cycle read-of-written-address returns the old value.
  - Writes to address 0 are ignored.
